// File: rtl/hs_spi_link_decoder_pkg.sv
// Shared definitions for the high-speed SPI link: header layout, opcodes,
// record kinds and the width helpers used by the bridges and the decoder.
package hs_spi_pkg;

    localparam int OPCODE_W = 2;

    typedef enum logic [OPCODE_W-1:0] {
        OP_NOP   = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10
    } opcode_t;

    typedef enum logic [1:0] {
        REC_HEADER = 2'd0,
        REC_WDATA  = 2'd1,
        REC_RDATA  = 2'd2
    } rec_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_RDATA = 2'd2
    } link_state_t;

    // Header layout for the default 32-bit link with a 256-word burst limit.
    localparam int HDR_DW = 32;
    localparam int HDR_CW = 9;
    localparam int HDR_AW = HDR_DW - OPCODE_W - HDR_CW;

    typedef struct packed {
        opcode_t             opcode;
        logic [HDR_CW-1:0]   count;
        logic [HDR_AW-1:0]   addr;
    } header_t;

    function automatic int opcode_w();
        return OPCODE_W;
    endfunction

    function automatic int align_w(input int dw);
        return $clog2(dw / 8);
    endfunction

    function automatic int count_w(input int max_burst);
        return $clog2(max_burst) + 1;
    endfunction

    function automatic int spi_aw(input int dw, input int max_burst);
        return dw - OPCODE_W - count_w(max_burst);
    endfunction

endpackage

// File: rtl/hs_spi_link_decoder_if.sv
// Record stream produced by the link decoder: one record per header or data
// word, plus error pulses and a busy flag.
interface hs_spi_link_decoder_if
    import hs_spi_pkg::*;
#(
    parameter int AW        = 10,
    parameter int DW        = 32,
    parameter int MAX_BURST = 256
) ();

    localparam int WAW = AW - align_w(DW);
    localparam int CW  = count_w(MAX_BURST);

    logic            rec_valid;
    logic            rec_ready;
    rec_kind_t       rec_kind;
    logic [DW-1:0]   rec_data;
    logic [WAW-1:0]  rec_addr;
    logic [CW-1:0]   rec_idx;
    logic            err_frame;
    logic            err_header;
    logic            err_overflow;
    logic            busy;

    modport master (
        output rec_valid, rec_kind, rec_data, rec_addr, rec_idx,
        output err_frame, err_header, err_overflow, busy,
        input  rec_ready
    );

    modport slave (
        input  rec_valid, rec_kind, rec_data, rec_addr, rec_idx,
        input  err_frame, err_header, err_overflow, busy,
        output rec_ready
    );

endinterface

// File: rtl/hs_spi_link_decoder_deser.sv
// Oversampling front end: synchronizes the link pins, detects SCK rising
// edges while CSn is low and assembles MSB-first words of SPI_W-bit beats.
module hs_spi_word_deser #(
    parameter int DW    = 32,
    parameter int SPI_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SCK,
    input  logic             CSn,
    input  logic [SPI_W-1:0] MOSI,
    input  logic [SPI_W-1:0] MISO,
    input  logic             lane_sel,
    output logic             word_valid,
    output logic [DW-1:0]    word,
    output logic             frame_err
);

    localparam int NIB = DW / SPI_W;
    localparam int BCW = (NIB > 1) ? $clog2(NIB) : 1;

    logic                  r_sck_s1, r_sck_s2, r_sck_d;
    logic                  r_csn_s1, r_csn_s2, r_csn_d;
    logic [SPI_W-1:0]      r_mosi_s1, r_mosi_s2;
    logic [SPI_W-1:0]      r_miso_s1, r_miso_s2;
    logic [DW-SPI_W-1:0]   r_shift;
    logic [DW-1:0]         r_word;
    logic [BCW-1:0]        r_bit_cnt;
    logic                  r_word_valid;
    logic                  r_frame_err;

    logic                  w_sck_rise;
    logic                  w_csn_rise;
    logic [SPI_W-1:0]      w_lane;
    logic [DW-1:0]         w_shift_next;

    assign w_sck_rise   = r_sck_s2 & ~r_sck_d & ~r_csn_s2;
    assign w_csn_rise   = r_csn_s2 & ~r_csn_d;
    assign w_lane       = lane_sel ? r_miso_s2 : r_mosi_s2;
    assign w_shift_next = {r_shift, w_lane};

    // Data lanes share the SCK synchronizer depth so each beat lines up with its edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_s1     <= 1'b0;
            r_sck_s2     <= 1'b0;
            r_sck_d      <= 1'b0;
            r_csn_s1     <= 1'b1;
            r_csn_s2     <= 1'b1;
            r_csn_d      <= 1'b1;
            r_mosi_s1    <= '0;
            r_mosi_s2    <= '0;
            r_miso_s1    <= '0;
            r_miso_s2    <= '0;
            r_shift      <= '0;
            r_word       <= '0;
            r_bit_cnt    <= '0;
            r_word_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_sck_s1     <= SCK;
            r_sck_s2     <= r_sck_s1;
            r_sck_d      <= r_sck_s2;
            r_csn_s1     <= CSn;
            r_csn_s2     <= r_csn_s1;
            r_csn_d      <= r_csn_s2;
            r_mosi_s1    <= MOSI;
            r_mosi_s2    <= r_mosi_s1;
            r_miso_s1    <= MISO;
            r_miso_s2    <= r_miso_s1;
            r_word_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (w_csn_rise) begin
                r_frame_err <= (r_bit_cnt != '0);
                r_bit_cnt   <= '0;
            end else if (w_sck_rise) begin
                r_shift <= w_shift_next[DW-SPI_W-1:0];
                if (r_bit_cnt == BCW'(NIB - 1)) begin
                    r_bit_cnt    <= '0;
                    r_word       <= w_shift_next;
                    r_word_valid <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + BCW'(1);
                end
            end
        end
    end

    assign word_valid = r_word_valid;
    assign word       = r_word;
    assign frame_err  = r_frame_err;

endmodule

// File: rtl/hs_spi_link_decoder.sv
// Passive bus monitor for the high-speed SPI link: decodes headers, tracks
// burst address/index and publishes one record per word with error pulses.
module hs_spi_link_decoder
    import hs_spi_pkg::*;
#(
    parameter int AW        = 10,
    parameter int DW        = 32,
    parameter int MAX_BURST = 256,
    parameter int SPI_W     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     SCK,
    input  logic                     CSn,
    input  logic [SPI_W-1:0]         MOSI,
    input  logic [SPI_W-1:0]         MISO,
    hs_spi_link_decoder_if.master    rec_if
);

    localparam int OPW   = opcode_w();
    localparam int ALIGN = align_w(DW);
    localparam int WAW   = AW - ALIGN;
    localparam int CW    = count_w(MAX_BURST);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

    logic            w_word_valid;
    logic [DW-1:0]   w_word;
    logic            w_frame_err;
    logic            w_lane_sel;

    opcode_t         w_hdr_op;
    logic [CW-1:0]   w_hdr_cnt;
    logic [WAW-1:0]  w_hdr_addr;
    logic            w_hdr_ok;

    link_state_t     r_state, w_state_next;
    logic [WAW-1:0]  r_addr, w_addr_next;
    logic [CW-1:0]   r_idx, w_idx_next;
    logic [CW-1:0]   r_count, w_count_next;

    logic            r_rec_valid, w_rec_valid_next;
    rec_kind_t       r_rec_kind, w_rec_kind_next;
    logic [DW-1:0]   r_rec_data, w_rec_data_next;
    logic [WAW-1:0]  r_rec_addr, w_rec_addr_next;
    logic [CW-1:0]   r_rec_idx, w_rec_idx_next;
    logic            r_err_frame, w_err_frame_next;
    logic            r_err_header, w_err_header_next;
    logic            r_err_overflow, w_err_overflow_next;

    logic            w_emit;
    rec_kind_t       w_emit_kind;
    logic [WAW-1:0]  w_emit_addr;
    logic [CW-1:0]   w_emit_idx;
    logic            w_load_ok;

    assign w_lane_sel = (r_state == ST_RDATA);

    hs_spi_word_deser #(
        .DW    (DW),
        .SPI_W (SPI_W)
    ) u_deser (
        .clk        (clk),
        .rst_n      (rst_n),
        .SCK        (SCK),
        .CSn        (CSn),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .lane_sel   (w_lane_sel),
        .word_valid (w_word_valid),
        .word       (w_word),
        .frame_err  (w_frame_err)
    );

    // Only the low word-address bits of the header address field reach the AVMM side.
    assign w_hdr_op   = opcode_t'(w_word[DW-1 -: OPW]);
    assign w_hdr_cnt  = w_word[DW-OPW-1 -: CW];
    assign w_hdr_addr = w_word[WAW-1:0];
    assign w_hdr_ok   = (w_hdr_cnt != '0) && (w_hdr_cnt <= MAX_CNT)
                        && ((w_hdr_op == OP_WRITE) || (w_hdr_op == OP_READ));
    assign w_load_ok  = !r_rec_valid || rec_if.rec_ready;

    always_comb begin
        w_state_next        = r_state;
        w_addr_next         = r_addr;
        w_idx_next          = r_idx;
        w_count_next        = r_count;
        w_rec_valid_next    = r_rec_valid && !rec_if.rec_ready;
        w_rec_kind_next     = r_rec_kind;
        w_rec_data_next     = r_rec_data;
        w_rec_addr_next     = r_rec_addr;
        w_rec_idx_next      = r_rec_idx;
        w_err_frame_next    = 1'b0;
        w_err_header_next   = 1'b0;
        w_err_overflow_next = 1'b0;
        w_emit              = 1'b0;
        w_emit_kind         = REC_HEADER;
        w_emit_addr         = r_addr;
        w_emit_idx          = r_idx;

        if (w_frame_err) begin
            w_err_frame_next = 1'b1;
            w_state_next     = ST_IDLE;
        end else if (w_word_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hdr_ok) begin
                        w_emit       = 1'b1;
                        w_emit_kind  = REC_HEADER;
                        w_emit_addr  = w_hdr_addr;
                        w_emit_idx   = '0;
                        w_addr_next  = w_hdr_addr;
                        w_idx_next   = '0;
                        w_count_next = w_hdr_cnt;
                        w_state_next = (w_hdr_op == OP_WRITE) ? ST_WDATA : ST_RDATA;
                    end else begin
                        w_err_header_next = 1'b1;
                    end
                end
                ST_WDATA, ST_RDATA: begin
                    w_emit      = 1'b1;
                    w_emit_kind = (r_state == ST_WDATA) ? REC_WDATA : REC_RDATA;
                    w_addr_next = r_addr + WAW'(1);
                    w_idx_next  = r_idx + CW'(1);
                    if ((r_idx + CW'(1)) == r_count) begin
                        w_state_next = ST_IDLE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end

        // A full, unaccepted output slot drops the new record; counters still advance.
        if (w_emit) begin
            if (w_load_ok) begin
                w_rec_valid_next = 1'b1;
                w_rec_kind_next  = w_emit_kind;
                w_rec_data_next  = w_word;
                w_rec_addr_next  = w_emit_addr;
                w_rec_idx_next   = w_emit_idx;
            end else begin
                w_err_overflow_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_addr         <= '0;
            r_idx          <= '0;
            r_count        <= '0;
            r_rec_valid    <= 1'b0;
            r_rec_kind     <= REC_HEADER;
            r_rec_data     <= '0;
            r_rec_addr     <= '0;
            r_rec_idx      <= '0;
            r_err_frame    <= 1'b0;
            r_err_header   <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_addr         <= w_addr_next;
            r_idx          <= w_idx_next;
            r_count        <= w_count_next;
            r_rec_valid    <= w_rec_valid_next;
            r_rec_kind     <= w_rec_kind_next;
            r_rec_data     <= w_rec_data_next;
            r_rec_addr     <= w_rec_addr_next;
            r_rec_idx      <= w_rec_idx_next;
            r_err_frame    <= w_err_frame_next;
            r_err_header   <= w_err_header_next;
            r_err_overflow <= w_err_overflow_next;
        end
    end

    assign rec_if.rec_valid    = r_rec_valid;
    assign rec_if.rec_kind     = r_rec_kind;
    assign rec_if.rec_data     = r_rec_data;
    assign rec_if.rec_addr     = r_rec_addr;
    assign rec_if.rec_idx      = r_rec_idx;
    assign rec_if.err_frame    = r_err_frame;
    assign rec_if.err_header   = r_err_header;
    assign rec_if.err_overflow = r_err_overflow;
    assign rec_if.busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_hs_spi_link_decoder.sv
// Directed and randomized link traffic; expected records come from a
// transaction-level model of header/burst rules kept in the bench.
module tb_hs_spi_link_decoder;
    import hs_spi_pkg::*;

    localparam int AW        = 10;
    localparam int DW        = 32;
    localparam int MAX_BURST = 256;
    localparam int SPI_W     = 4;
    localparam int WAW       = 8;
    localparam int CW        = 9;

    typedef struct packed {
        logic [1:0]     kind;
        logic [DW-1:0]  data;
        logic [WAW-1:0] addr;
        logic [CW-1:0]  idx;
    } rec_t;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             SCK   = 1'b0;
    logic             CSn   = 1'b1;
    logic [SPI_W-1:0] MOSI  = '0;
    logic [SPI_W-1:0] MISO  = '0;

    int total = 0;
    int bad   = 0;
    int n_frame = 0, n_header = 0, n_over = 0;
    int exp_frame = 0, exp_header = 0, exp_over = 0;

    rec_t            got_q[$];
    rec_t            exp_q[$];
    logic [DW-1:0]   data_q[$];

    always #5 clk = ~clk;

    hs_spi_link_decoder_if #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) rec_if ();

    hs_spi_link_decoder #(
        .AW(AW), .DW(DW), .MAX_BURST(MAX_BURST), .SPI_W(SPI_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .SCK    (SCK),
        .CSn    (CSn),
        .MOSI   (MOSI),
        .MISO   (MISO),
        .rec_if (rec_if)
    );

    always @(negedge clk) begin
        if (rec_if.rec_valid && rec_if.rec_ready)
            got_q.push_back({rec_if.rec_kind, rec_if.rec_data, rec_if.rec_addr, rec_if.rec_idx});
        if (rec_if.err_frame)    n_frame++;
        if (rec_if.err_header)   n_header++;
        if (rec_if.err_overflow) n_over++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic rec_t mk_rec(input int kind, input logic [DW-1:0] d, input int addr, input int idx);
        rec_t r;
        r.kind = 2'(kind);
        r.data = d;
        r.addr = WAW'(addr % (1 << WAW));
        r.idx  = CW'(idx);
        return r;
    endfunction

    task automatic send_nibbles(input logic [DW-1:0] w, input int n, input bit on_miso);
        for (int i = 0; i < n; i++) begin
            logic [SPI_W-1:0] nib;
            nib = w[DW-1-SPI_W*i -: SPI_W];
            if (on_miso) begin
                MISO = nib;
                MOSI = SPI_W'($urandom);
            end else begin
                MOSI = nib;
                MISO = SPI_W'($urandom);
            end
            tick(3);
            SCK = 1'b1;
            tick(3);
            SCK = 1'b0;
        end
    endtask

    task automatic send_word(input logic [DW-1:0] w, input bit on_miso);
        send_nibbles(w, DW / SPI_W, on_miso);
    endtask

    function automatic logic [DW-1:0] mk_hdr(input logic [1:0] op, input int cnt, input int addr);
        return {op, CW'(cnt), 21'(addr)};
    endfunction

    // Full transaction in one CSn window; data words come from data_q first, else random.
    task automatic run_txn(input logic [1:0] op, input int cnt, input int addr);
        logic [DW-1:0] hdr;
        logic [DW-1:0] d;
        bit ok;
        hdr = mk_hdr(op, cnt, addr);
        ok = ((op == 2'b10) || (op == 2'b01)) && (cnt >= 1) && (cnt <= MAX_BURST);
        CSn = 1'b0;
        tick(3);
        send_word(hdr, 1'b0);
        if (ok) begin
            exp_q.push_back(mk_rec(0, hdr, addr, 0));
            for (int i = 0; i < cnt; i++) begin
                d = (data_q.size() != 0) ? data_q.pop_front() : DW'($urandom);
                send_word(d, op == 2'b01);
                exp_q.push_back(mk_rec((op == 2'b10) ? 1 : 2, d, addr + i, i));
            end
        end else begin
            exp_header++;
        end
        tick(8);
        CSn = 1'b1;
        tick(3);
    endtask

    task automatic check_queue(input string tag);
        check({tag, "_nrec"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check(tag, 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [DW-1:0] d0;
        logic [1:0]    op;
        int            hdr0;

        rec_if.rec_ready = 1'b0;
        tick(3);
        check("rst_valid", 64'(rec_if.rec_valid), 64'd0);
        check("rst_busy",  64'(rec_if.busy), 64'd0);
        check("rst_data",  64'(rec_if.rec_data), 64'd0);
        check("rst_errs",  64'({rec_if.err_frame, rec_if.err_header, rec_if.err_overflow}), 64'd0);
        rst_n = 1'b1;
        tick(3);
        rec_if.rec_ready = 1'b1;

        data_q.push_back(32'hDEADBEEF);
        data_q.push_back(32'h01234567);
        run_txn(2'b10, 2, 'h10);
        check_queue("write2");
        check("write2_busy", 64'(rec_if.busy), 64'd0);

        data_q.push_back(32'hCAFEF00D);
        run_txn(2'b01, 1, 'hFF);
        run_txn(2'b01, 2, 'hFF);
        check_queue("read_wrap");

        hdr0 = n_header;
        run_txn(2'b11, 1, 'h12);
        check("bad_op_busy", 64'(rec_if.busy), 64'd0);
        run_txn(2'b10, 0, 'h12);
        check("cnt0_busy", 64'(rec_if.busy), 64'd0);
        run_txn(2'b01, MAX_BURST + 1, 'h12);
        run_txn(2'b00, 3, 'h12);
        check("hdr_err_pulses", 64'(n_header - hdr0), 64'd4);
        check_queue("bad_hdr");

        // CSn rises three nibbles into a write data word.
        CSn = 1'b0;
        tick(3);
        send_word(mk_hdr(2'b10, 2, 'h40), 1'b0);
        exp_q.push_back(mk_rec(0, mk_hdr(2'b10, 2, 'h40), 'h40, 0));
        send_nibbles(DW'($urandom), 3, 1'b0);
        tick(3);
        CSn = 1'b1;
        exp_frame++;
        tick(8);
        check("frame_cnt", 64'(n_frame), 64'(exp_frame));
        check("frame_busy", 64'(rec_if.busy), 64'd0);
        run_txn(2'b01, 1, 'h05);
        check_queue("after_frame");

        // Consumer stalls across a 4-word write after the header is taken.
        CSn = 1'b0;
        tick(3);
        send_word(mk_hdr(2'b10, 4, 'h20), 1'b0);
        exp_q.push_back(mk_rec(0, mk_hdr(2'b10, 4, 'h20), 'h20, 0));
        tick(6);
        rec_if.rec_ready = 1'b0;
        d0 = DW'($urandom);
        send_word(d0, 1'b0);
        for (int i = 1; i < 4; i++) send_word(DW'($urandom), 1'b0);
        exp_over += 3;
        tick(8);
        check("ovf_held_valid", 64'(rec_if.rec_valid), 64'd1);
        check("ovf_held_rec", 64'({rec_if.rec_kind, rec_if.rec_data, rec_if.rec_addr, rec_if.rec_idx}),
              64'(mk_rec(1, d0, 'h20, 0)));
        check("ovf_cnt", 64'(n_over), 64'(exp_over));
        check("ovf_busy", 64'(rec_if.busy), 64'd0);
        exp_q.push_back(mk_rec(1, d0, 'h20, 0));
        rec_if.rec_ready = 1'b1;
        tick(3);
        CSn = 1'b1;
        tick(3);
        check_queue("overflow");

        for (int t = 0; t < 15; t++) begin
            case ($urandom_range(0, 5))
                0, 1:    op = 2'b10;
                2, 3:    op = 2'b01;
                4:       op = 2'b11;
                default: op = 2'b00;
            endcase
            run_txn(op, int'($urandom_range(0, 4)), int'($urandom_range(0, 255)));
        end
        check_queue("random");
        check("hdr_err_total", 64'(n_header), 64'(exp_header));

        run_txn(2'b10, MAX_BURST, 'h80);
        check_queue("max_burst");

        // Asynchronous reset while a record is held and a burst is in flight.
        rec_if.rec_ready = 1'b0;
        CSn = 1'b0;
        tick(3);
        send_word(mk_hdr(2'b10, 4, 'h30), 1'b0);
        send_word(DW'($urandom), 1'b0);
        exp_over++;
        send_nibbles(DW'($urandom), 3, 1'b0);
        check("pre_rst_valid", 64'(rec_if.rec_valid), 64'd1);
        check("pre_rst_busy", 64'(rec_if.busy), 64'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(rec_if.rec_valid), 64'd0);
        check("arst_busy", 64'(rec_if.busy), 64'd0);
        check("arst_rec", 64'({rec_if.rec_kind, rec_if.rec_data, rec_if.rec_addr, rec_if.rec_idx}), 64'd0);
        SCK = 1'b0;
        CSn = 1'b1;
        rec_if.rec_ready = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(3);
        run_txn(2'b10, 1, 'h07);
        check_queue("after_rst");

        check("frame_total", 64'(n_frame), 64'(exp_frame));
        check("ovf_total", 64'(n_over), 64'(exp_over));
        check("hdr_total", 64'(n_header), 64'(exp_header));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
